maze_buffer_writer: RTL and testbench

- Producer side of the ping-pong maze frame buffer that the display path reads. The display path reads pixel `xpos*264 + (ypos-24)`, covering tile rows 3-35.
- Walks the 30x33 tile map, expands each tile through the 8x8 pattern ROM into 8-bit RGB332 colours, and writes them into the back buffer.
- Swaps front/back buffers only at frame start, so the display never shows a partially drawn maze.

---
 rtl/maze_gfx_pkg.sv | 17 +
 rtl/maze_pixel_colorizer.sv | 23 ++
 rtl/maze_buffer_writer.sv | 97 +++++++++
 tb/tb_maze_buffer_writer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/maze_gfx_pkg.sv
// maze_gfx_pkg: shared constants and types for the maze frame-buffer renderer
package maze_gfx_pkg;
    localparam int TILE_COLS = 30;
    localparam int TILE_ROWS = 33;
    localparam int BUF_H = 264;
    localparam int YOFFSET = 24;
    localparam logic [7:0] BLK = 8'h00;
    localparam logic [7:0] BLU = 8'h03;
    localparam logic [7:0] CRM = 8'hFE;
    localparam logic [7:0] DOT_COLOR = CRM;
    typedef enum logic [1:0] {PIX_BLANK, PIX_WALL, PIX_DOT, PIX_PELLET} pix_code_t;
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, FLUSH, DONE} state_t;
    // Column-major buffer layout: one BUF_H-pixel column per screen x.
    function automatic logic [15:0] buf_addr(input logic [7:0] x, input logic [8:0] y);
        return 16'(x * BUF_H + y);
    endfunction
endpackage

// File: rtl/maze_pixel_colorizer.sv
// maze_pixel_colorizer: registered pattern-code to RGB332 colour map
module maze_pixel_colorizer
    import maze_gfx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pat_pixel,
    input  logic [7:0] wall_color,
    input  logic       pellet_on,
    output logic [7:0] color
);
    pix_code_t code;
    logic [7:0] next_color;
    always_comb begin
        code = pix_code_t'(pat_pixel);
        next_color = code == PIX_WALL ? wall_color :
                     (code == PIX_DOT || (code == PIX_PELLET && pellet_on)) ? DOT_COLOR : BLK;
    end
    always_ff @(posedge clk) begin
        if (rst) color <= BLK;
        else color <= next_color;
    end
endmodule

// File: rtl/maze_buffer_writer.sv
// maze_buffer_writer: renders the tile map into the back half of a ping-pong frame buffer
module maze_buffer_writer
    import maze_gfx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [7:0]  wall_color,
    input  logic        pellet_on,
    output logic [9:0]  tile_addr,
    input  logic [4:0]  tile_data,
    output logic [10:0] pat_addr,
    input  logic [1:0]  pat_pixel,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        disp_sel,
    output logic        busy,
    output logic        render_done,
    output logic        overrun
);
    state_t state, next_state;
    logic [4:0] tcol, tile_id;
    logic [5:0] trow;
    logic [2:0] px, py;
    logic issue, tile_end, col_end, last_tile, swap;
    logic pix_vld;
    logic [7:0] pix_x;
    logic [8:0] pix_y;

    // Pixel 0 is issued in WAIT straight from tile_data so that the two-stage
    // ROM+colour pipeline drains into the next FETCH, keeping a tile at 66 cycles.
    always_comb begin
        issue = state == WAIT || (state == DRAW && {py, px} != 6'd0);
        tile_end = state == DRAW && {py, px} == 6'd0;
        col_end = tcol == 5'(TILE_COLS - 1);
        last_tile = col_end && trow == 6'(TILE_ROWS - 1);
        swap = state == DONE && frame_start;
        busy = state inside {FETCH, WAIT, DRAW, FLUSH};
        tile_addr = 10'(trow * TILE_COLS + tcol);
        pat_addr = {state == WAIT ? tile_data : tile_id, py, px};
        next_state = state;
        case (state)
            IDLE:    next_state = frame_start ? FETCH : IDLE;
            FETCH:   next_state = WAIT;
            WAIT:    next_state = DRAW;
            DRAW:    next_state = tile_end ? (last_tile ? FLUSH : FETCH) : DRAW;
            FLUSH:   next_state = DONE;
            DONE:    next_state = frame_start ? FETCH : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tcol <= '0;
            trow <= '0;
            px <= '0;
            py <= '0;
            tile_id <= '0;
            disp_sel <= 1'b0;
            render_done <= 1'b0;
            overrun <= 1'b0;
            pix_vld <= 1'b0;
            pix_x <= '0;
            pix_y <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
        end else begin
            state <= next_state;
            render_done <= state == FLUSH;
            overrun <= frame_start && busy;
            if (swap) disp_sel <= ~disp_sel;
            if (state == WAIT) tile_id <= tile_data;
            if (issue) {py, px} <= {py, px} + 6'd1;
            if (tile_end) begin
                tcol <= col_end ? 5'd0 : tcol + 5'd1;
                trow <= last_tile ? 6'd0 : trow + 6'(col_end);
            end
            pix_vld <= issue;
            pix_x <= {tcol, px};
            pix_y <= {trow, py};
            wr_en <= pix_vld;
            wr_addr <= buf_addr(pix_x, pix_y);
        end
    end

    maze_pixel_colorizer u_color (
        .clk        (clk),
        .rst        (rst),
        .pat_pixel  (pat_pixel),
        .wall_color (wall_color),
        .pellet_on  (pellet_on),
        .color      (wr_data)
    );
endmodule

// File: tb/tb_maze_buffer_writer.sv
// tb_maze_buffer_writer: random tile map and patterns, each write checked against ascending-tile-order model
module tb_maze_buffer_writer;
    localparam int NPIX = 63360;

    logic clk, rst, frame_start, pellet_on;
    logic [7:0] wall_color;
    logic [9:0] tile_addr;
    logic [4:0] tile_data;
    logic [10:0] pat_addr;
    logic [1:0] pat_pixel;
    logic wr_en, disp_sel, busy, render_done, overrun;
    logic [15:0] wr_addr;
    logic [7:0] wr_data;

    logic [4:0] tmap [990];
    logic [1:0] pat [2048];
    bit seen [NPIX];
    int fr, total, bad, n, wsave;
    int wcnt [3], aerr [3], derr [3];
    int dup, oob, c3on, c3off;
    logic [7:0] d2925;
    logic [7:0] prev_wall;
    logic prev_pellet;

    maze_buffer_writer dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .wall_color  (wall_color),
        .pellet_on   (pellet_on),
        .tile_addr   (tile_addr),
        .tile_data   (tile_data),
        .pat_addr    (pat_addr),
        .pat_pixel   (pat_pixel),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .disp_sel    (disp_sel),
        .busy        (busy),
        .render_done (render_done),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tile_data <= tmap[tile_addr];
    always @(posedge clk) pat_pixel <= pat[pat_addr];

    function automatic logic [7:0] colour(input int code, input logic [7:0] w, input logic p);
        case (code)
            1: return w;
            2: return 8'hFE;
            3: return p ? 8'hFE : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // k-th write of a render must be pixel k in tile-row, tile-col, py, px order.
    always @(negedge clk) begin : mon
        int k, tile, r, tc, tr, ea, code;
        logic [7:0] ed;
        if (wr_en) begin
            k = wcnt[fr];
            if (k >= NPIX) aerr[fr] <= aerr[fr] + 1;
            else begin
                tile = k / 64;
                r = k % 64;
                tr = tile / 30;
                tc = tile % 30;
                ea = (tc * 8 + r % 8) * 264 + tr * 8 + r / 8;
                code = int'(pat[int'(tmap[tile]) * 64 + r]);
                ed = colour(code, prev_wall, prev_pellet);
                if (int'(wr_addr) != ea) aerr[fr] <= aerr[fr] + 1;
                if (wr_data !== ed) derr[fr] <= derr[fr] + 1;
                if (fr == 0 && code == 3 && wr_data === ed) begin
                    if (prev_pellet) c3on <= c3on + 1;
                    else c3off <= c3off + 1;
                end
            end
            if (fr == 0) begin
                if (int'(wr_addr) < NPIX) begin
                    if (seen[wr_addr]) dup <= dup + 1;
                    seen[wr_addr] <= 1'b1;
                end else oob <= oob + 1;
                if (wr_addr == 16'd2925) d2925 <= wr_data;
            end
            wcnt[fr] <= k + 1;
        end
        prev_wall <= wall_color;
        prev_pellet <= pellet_on;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wall_color = 8'($urandom);
        pellet_on = 1'($urandom);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 990; i++) tmap[i] = 5'($urandom);
        for (int i = 0; i < 2048; i++) pat[i] = 2'($urandom);
        pat[{tmap[2 * 30 + 1], 3'd5, 3'd3}] = 2'd2;
        rst = 1'b1;
        frame_start = 1'b0;
        wall_color = 8'h00;
        pellet_on = 1'b0;
        fr = 0;
        tick();
        tick();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_disp_sel", 32'(disp_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_render_done", 32'(render_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_tile_addr", 32'(tile_addr), 0);
        chk("rst_pat_addr", 32'(pat_addr), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 0);

        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("f0_busy", 32'(busy), 1);
        n = 0;
        while (n < 70000 && !render_done) begin
            tick();
            n++;
            if (n == 20000) frame_start = 1'b1;
            else if (n == 20001) begin
                frame_start = 1'b0;
                chk("overrun_pulse", 32'(overrun), 1);
                chk("overrun_no_swap", 32'(disp_sel), 0);
            end else if (n == 20002) chk("overrun_clear", 32'(overrun), 0);
        end
        chk("done_cycle", 32'(n), 65341);
        chk("done_busy", 32'(busy), 0);
        chk("done_disp_sel", 32'(disp_sel), 0);
        tick();
        chk("done_pulse_clear", 32'(render_done), 0);
        repeat (4) tick();
        chk("f0_writes", 32'(wcnt[0]), NPIX);
        chk("f0_addr_err", 32'(aerr[0]), 0);
        chk("f0_data_err", 32'(derr[0]), 0);
        chk("f0_dup", 32'(dup), 0);
        chk("f0_oob", 32'(oob), 0);
        chk("dot_2925", 32'(d2925), 32'hFE);
        chk("pellet_on_seen", 32'(c3on > 0), 1);
        chk("pellet_off_seen", 32'(c3off > 0), 1);

        fr = 1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("swap_disp_sel", 32'(disp_sel), 1);
        chk("f1_busy", 32'(busy), 1);
        repeat (300) tick();
        chk("f1_writes", 32'(wcnt[1] > 0), 1);
        chk("f1_addr_err", 32'(aerr[1]), 0);
        chk("f1_data_err", 32'(derr[1]), 0);
        rst = 1'b1;
        tick();
        chk("midrst_wr_en", 32'(wr_en), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_disp_sel", 32'(disp_sel), 0);
        chk("midrst_tile_addr", 32'(tile_addr), 0);
        rst = 1'b0;
        wsave = wcnt[1];
        repeat (5) tick();
        chk("midrst_no_writes", 32'(wcnt[1]), 32'(wsave));
        chk("midrst_idle", 32'(busy), 0);

        fr = 2;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("f2_busy", 32'(busy), 1);
        chk("f2_disp_sel", 32'(disp_sel), 0);
        repeat (200) tick();
        chk("f2_writes", 32'(wcnt[2] > 0), 1);
        chk("f2_addr_err", 32'(aerr[2]), 0);
        chk("f2_data_err", 32'(derr[2]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
